// File: rtl/tx_symbol_controller.sv
// TX symbol framer: forwards coded bits to the interleaver one OFDM symbol at a time,
// frames each symbol with start/last strobes and zero-pads the final symbol.
module tx_symbol_controller #(
  parameter int LEN_W = 16,
  parameter int SYM_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       rate_i,
  input  logic [LEN_W-1:0] num_bits_i,
  input  logic             in_bit_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             out_bit_o,
  output logic             out_valid_o,
  output logic             sym_start_o,
  output logic             sym_last_o,
  output logic [8:0]       n_cbps_o,
  output logic [SYM_W-1:0] sym_count_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [8:0]       ncbps_q, ncbps_d;
  logic [8:0]       bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [SYM_W-1:0] sym_count_q, sym_count_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             sym_start_q, sym_start_d;
  logic             sym_last_q, sym_last_d;

  logic             xfer;
  logic             at_last;
  logic             at_first;

  function automatic logic [8:0] rate_to_ncbps(input logic [1:0] rate);
    logic [8:0] n;
    case (rate)
      2'd0:    n = 9'd48;
      2'd1:    n = 9'd96;
      2'd2:    n = 9'd192;
      default: n = 9'd288;
    endcase
    return n;
  endfunction

  assign in_ready_o = (state_q == S_DATA);
  assign xfer       = in_valid_i && in_ready_o;
  assign at_last    = (bit_cnt_q == (ncbps_q - 9'd1));
  assign at_first   = (bit_cnt_q == 9'd0);

  always_comb begin
    state_d     = state_q;
    ncbps_d     = ncbps_q;
    bit_cnt_d   = bit_cnt_q;
    remaining_d = remaining_q;
    sym_count_d = sym_count_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    sym_start_d = 1'b0;
    sym_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ncbps_d     = rate_to_ncbps(rate_i);
          remaining_d = num_bits_i;
          bit_cnt_d   = 9'd0;
          sym_count_d = '0;
          state_d     = (num_bits_i == '0) ? S_DONE : S_DATA;
        end
      end

      S_DATA: begin
        if (xfer) begin
          out_bit_d   = in_bit_i;
          out_valid_d = 1'b1;
          sym_start_d = at_first;
          sym_last_d  = at_last;
          bit_cnt_d   = at_last ? 9'd0 : bit_cnt_q + 9'd1;
          if (at_last) sym_count_d = sym_count_q + SYM_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = at_last ? S_DONE : S_PAD;
        end
      end

      S_PAD: begin
        out_bit_d   = 1'b0;
        out_valid_d = 1'b1;
        sym_start_d = at_first;
        sym_last_d  = at_last;
        bit_cnt_d   = at_last ? 9'd0 : bit_cnt_q + 9'd1;
        if (at_last) begin
          sym_count_d = sym_count_q + SYM_W'(1);
          state_d     = S_DONE;
        end
      end

      default: begin
        // Linger while the final bit is still on the output so Done follows it.
        if (!out_valid_q) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ncbps_q     <= 9'd48;
      bit_cnt_q   <= 9'd0;
      remaining_q <= '0;
      sym_count_q <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
      sym_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ncbps_q     <= ncbps_d;
      bit_cnt_q   <= bit_cnt_d;
      remaining_q <= remaining_d;
      sym_count_q <= sym_count_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      sym_start_q <= sym_start_d;
      sym_last_q  <= sym_last_d;
    end
  end

  assign out_bit_o   = out_bit_q;
  assign out_valid_o = out_valid_q;
  assign sym_start_o = sym_start_q;
  assign sym_last_o  = sym_last_q;
  assign n_cbps_o    = ncbps_q;
  assign sym_count_o = sym_count_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE) && !out_valid_q;

endmodule

// File: tb/tb_tx_symbol_controller.sv
// Scoreboard bench for tx_symbol_controller: expected output bits/strobes are queued
// as stimulus is driven and popped whenever the DUT presents a valid output bit.
module tb_tx_symbol_controller;
  localparam int LEN_W = 16;
  localparam int SYM_W = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       rate = 2'd0;
  logic [LEN_W-1:0] num_bits = '0;
  logic             in_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready_o, out_bit_o, out_valid_o, sym_start_o, sym_last_o;
  logic [8:0]       n_cbps_o;
  logic [SYM_W-1:0] sym_count_o;
  logic             busy_o, done_o;

  tx_symbol_controller #(.LEN_W(LEN_W), .SYM_W(SYM_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rate_i(rate), .num_bits_i(num_bits),
    .in_bit_i(in_bit), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .out_bit_o(out_bit_o), .out_valid_o(out_valid_o), .sym_start_o(sym_start_o),
    .sym_last_o(sym_last_o), .n_cbps_o(n_cbps_o), .sym_count_o(sym_count_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [2:0] sbq[$];
  int         out_cnt = 0;
  int         cur_n = 48;
  int         cur_nb = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ncbps_of(input logic [1:0] r);
    case (r)
      2'd0:    return 48;
      2'd1:    return 96;
      2'd2:    return 192;
      default: return 288;
    endcase
  endfunction

  // Output monitor: {bit, sym_start, sym_last} against the scoreboard head
  always @(negedge clk) begin : mon
    logic [2:0] e;
    if (rst_n && out_valid_o) begin
      if (sbq.size() == 0) check_eq("unexpected_out", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        check_eq("out_bit_start_last", {29'd0, out_bit_o, sym_start_o, sym_last_o}, {29'd0, e});
      end
      out_cnt++;
    end
  end

  task automatic do_start(input logic [1:0] r, input int nb);
    rate = r;
    num_bits = nb[LEN_W-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cur_n = ncbps_of(r);
    cur_nb = nb;
    out_cnt = 0;
    check_eq("busy_after_start", busy_o, 1);
    check_eq("ready_after_start", in_ready_o, nb != 0);
    check_eq("ncbps_latched", n_cbps_o, cur_n);
  endtask

  // mode 0: In_Valid held high, mode 1: toggling 1010...; poke pulses Start/Rate mid-packet
  task automatic do_body(input int mode, input bit poke);
    int i, cyc, c, syms;
    logic v, prev;
    i = 0; cyc = 0; prev = 1'b0;
    syms = (cur_nb + cur_n - 1) / cur_n;
    while (i < cur_nb) begin
      v = (mode == 0) ? 1'b1 : ~cyc[0];
      in_valid = v;
      in_bit = 1'($urandom_range(0, 1));
      if (poke && i == 10) begin
        start = 1'b1; rate = 2'd3; num_bits = 16'd5;
      end else start = 1'b0;
      if (v) sbq.push_back({in_bit, 1'((i % cur_n) == 0), 1'((i % cur_n) == cur_n - 1)});
      @(posedge clk); #1;
      if (v) i++;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    for (int k = cur_nb; k < syms * cur_n; k++)
      sbq.push_back({1'b0, 1'((k % cur_n) == 0), 1'((k % cur_n) == cur_n - 1)});
    for (c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done_o) break;
      prev = sym_last_o & out_valid_o;
    end
    if (c >= 600) check_eq("done_timeout", 32'd0, 32'd1);
    else begin
      check_eq("done_out_valid", out_valid_o, 0);
      check_eq("busy_in_done", busy_o, 1);
      check_eq("sym_count", sym_count_o, syms);
      check_eq("last_before_done", prev, cur_nb != 0);
      check_eq("sb_empty", sbq.size(), 0);
      check_eq("out_count", out_cnt, syms * cur_n);
      check_eq("ncbps_hold", n_cbps_o, cur_n);
      if (cur_nb == 0) check_eq("zero_done_latency", c, 0);
    end
  endtask

  task automatic idle_check(input int syms);
    @(negedge clk);
    check_eq("done_one_cycle", done_o, 0);
    check_eq("idle_busy", busy_o, 0);
    check_eq("sym_count_hold", sym_count_o, syms);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready_o, 0);
    check_eq({tag, "_out_bit"}, out_bit_o, 0);
    check_eq({tag, "_out_valid"}, out_valid_o, 0);
    check_eq({tag, "_sym_start"}, sym_start_o, 0);
    check_eq({tag, "_sym_last"}, sym_last_o, 0);
    check_eq({tag, "_ncbps"}, n_cbps_o, 48);
    check_eq({tag, "_sym_count"}, sym_count_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BPSK, exactly one symbol
    do_start(2'd0, 48);
    do_body(0, 1'b0);
    idle_check(1);

    // QPSK, 100 bits -> 2 symbols, 92 pad zeros
    do_start(2'd1, 100);
    do_body(0, 1'b0);
    idle_check(2);

    // 64-QAM, 300 bits with gapped input -> 276 pad zeros
    do_start(2'd3, 300);
    do_body(1, 1'b0);
    idle_check(2);

    // empty packet
    do_start(2'd2, 0);
    do_body(0, 1'b0);
    idle_check(0);

    // Start/Rate poked mid-packet, then Start held across the Done cycle
    do_start(2'd1, 96);
    do_body(0, 1'b1);
    start = 1'b1; rate = 2'd0; num_bits = 16'd48;
    @(posedge clk); #1;
    check_eq("start_in_done_ignored", busy_o, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_after_done_busy", busy_o, 1);
    check_eq("start_after_done_ncbps", n_cbps_o, 48);
    cur_n = 48; cur_nb = 48; out_cnt = 0;
    do_body(0, 1'b0);
    idle_check(1);

    // reset mid-packet at bit 30 of a 16-QAM packet
    do_start(2'd2, 400);
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_bit = 1'($urandom_range(0, 1));
      sbq.push_back({in_bit, 1'(i == 0), 1'b0});
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", done_o, 0);
      check_eq("post_rst_valid", out_valid_o, 0);
    end
    do_start(2'd0, 48);
    do_body(0, 1'b0);
    idle_check(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_symbol_controller.md
# tx_symbol_controller

Sequences coded bits from the convolutional encoder into the block interleaver one OFDM symbol at a time. Latches the per-packet rate and emits the matching N_CBPS, and frames each symbol with start/last strobes. Zero-pads the final symbol to a full N_CBPS bits and reports completion. Sits between the encoder/puncturer output and the interleaver input on the TX path.

## Interface
- LEN_W, 16: width of the packet coded-bit count
- SYM_W, 11: width of the completed-symbol counter
- Clock  in  1  rising-edge system clock
- Reset  in  1  asynchronous, active-low; all state and outputs clear while low
- Start  in  1  packet start request; accepted only in IDLE
- Rate  in  2  modulation code: 0 BPSK (48), 1 QPSK (96), 2 16-QAM (192), 3 64-QAM (288); sampled with Start
- Num_Bits  in  LEN_W  coded bits in the packet; sampled with Start
- In_Bit  in  1  coded bit from the encoder
- In_Valid  in  1  In_Bit valid
- In_Ready  out  1  controller accepts In_Bit this cycle
- Out_Bit  out  1  bit to the interleaver
- Out_Valid  out  1  Out_Bit valid; the interleaver advances only when this is high
- Sym_Start  out  1  Out_Bit is bit 0 of a symbol
- Sym_Last  out  1  Out_Bit is bit N_CBPS-1 of a symbol
- N_CBPS  out  9  latched coded bits per symbol, for the interleaver
- Sym_Count  out  SYM_W  symbols completed in the current or last packet
- Busy  out  1  state is not IDLE
- Done  out  1  one-cycle end-of-packet strobe

## Operation
- States: IDLE, DATA, PAD, DONE.
- IDLE:
  - On Start, latch Rate into N_CBPS (48/96/192/288) and Num_Bits into remaining.
  - Clear bit_cnt (9 b) and Sym_Count.
  - Go to DATA, or to DONE if Num_Bits == 0.
- DATA:
  - In_Ready = 1, decoded from the state register only.
  - A transfer is In_Valid && In_Ready.
  - On each transfer: register Out_Bit = In_Bit and Out_Valid = 1. Set Sym_Start = (bit_cnt == 0) and Sym_Last = (bit_cnt == N_CBPS-1).
  - On each transfer: bit_cnt increments and wraps to 0 after N_CBPS-1. Sym_Count increments on the wrap. remaining decrements.
  - Transfer with remaining == 1: go to DONE if bit_cnt == N_CBPS-1, else go to PAD.
  - A cycle with no transfer registers Out_Valid = 0. Sym_Start and Sym_Last are 0. bit_cnt is held.
- PAD:
  - In_Ready = 0.
  - Every cycle emits Out_Bit = 0 with Out_Valid = 1, and Sym_Last on bit_cnt == N_CBPS-1.
  - On that last pad bit: Sym_Count increments, go to DONE.
- DONE:
  - Done = 1 and Busy = 1 for exactly one cycle.
  - Out_Valid = 0.
  - Go to IDLE.
- Start is ignored in DATA, PAD and DONE. Rate and Num_Bits changes are ignored outside the Start sample.
- Sym_Count holds its final value in IDLE until the next accepted Start.
- Symbols per packet = ceil(Num_Bits / N_CBPS). Pad bits = symbols*N_CBPS − Num_Bits.
- Counters never overflow for legal input: max 65535 bits / 48 = 1366 symbols < 2^11.

## Timing
- Reset values:
  - State IDLE, In_Ready 0, Out_Bit 0, Out_Valid 0, Sym_Start 0, Sym_Last 0.
  - N_CBPS 48, Sym_Count 0, Busy 0, Done 0.
- Start sampled at edge E: Busy and In_Ready go high after E.
- The first transfer can occur at edge E+1.
- Out_* latency is one cycle: a bit transferred at edge T appears on Out_Bit, Out_Valid, Sym_Start and Sym_Last between T and T+1.
- Pad bits are emitted back-to-back with no gaps. The first pad bit directly follows the last data bit.
- Done is high in the cycle immediately after the cycle carrying the final Sym_Last.
- For Num_Bits == 0, Done is high in the cycle after the Start edge, and no Out_Valid is issued.
- A new Start is accepted at the earliest in the cycle after Done.
- Reset asserted mid-packet clears everything immediately, including partial symbol state. No pad bits and no Done are emitted.

## Test plan
- BPSK, Num_Bits = 48, In_Valid held high:
  - 48 Out_Valid cycles.
  - Sym_Start on bit 0, Sym_Last on bit 47.
  - Zero pad bits, Sym_Count = 1.
  - Done one cycle later.
  - Out_Bit sequence equals In_Bit sequence delayed by 1 cycle.
- QPSK, Num_Bits = 100:
  - 2 symbols (N_CBPS = 96).
  - Bits 100..191 of output are 92 contiguous zeros.
  - Sym_Last at output bits 95 and 191, Sym_Count = 2.
- 64-QAM, Num_Bits = 300, In_Valid toggling 1010…:
  - Out_Valid mirrors transfers with one cycle delay.
  - bit_cnt is held across gaps.
  - 276 pad zeros, Sym_Count = 2.
- Num_Bits = 0:
  - No Out_Valid.
  - Done high in the cycle after Start, Sym_Count = 0.
- Start and a different Rate pulsed in DATA: no effect, N_CBPS unchanged. Start in the Done cycle is ignored; Start one cycle later is accepted.
- Reset low at bit 30 of a 16-QAM packet:
  - All outputs at reset values immediately; Done never asserted.
  - A following BPSK packet of 48 bits completes normally.
